// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings and counter width helper shared by the serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Full_Subtractor: one-bit cell, Dif = X-Y-Bi, Bo = borrow-out; ports X, Y, Bi in, Dif, Bo out
module Full_Subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bi,
  output logic Dif,
  output logic Bo
);
  logic xy;
  assign xy  = X ^ Y;
  assign Dif = xy ^ Bi;
  assign Bo  = (~X & Y) | (~xy & Bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first D = A-B-Bin, one bit per CLK; Start in, Busy/Done out, D/Bout registered results
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_n;
  logic [CW-1:0] cnt;
  logic br, d_bit, br_n, last;
  Full_Subtractor u_fs (.X(a_sr[0]), .Y(b_sr[0]), .Bi(br), .Dif(d_bit), .Bo(br_n));
  assign last = cnt == CW'(WIDTH - 1);
  assign r_n  = WIDTH'({d_bit, r_sr} >> 1);
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (Start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && Start) begin
        a_sr <= A;
        b_sr <= B;
        br   <= Bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_n;
        br   <= br_n;
        cnt  <= cnt + 1'b1;
        if (last) begin
          D    <= r_n;
          Bout <= br_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random self-checking bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  localparam int W = 8;
  logic CLK = 1'b0, RST = 1'b1, Start = 1'b0, Bin = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic Busy, Done, Bout;
  logic [W-1:0] D;
  int vecs = 0, errs = 0;
  always #5 CLK = ~CLK;
  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .D(D), .Bout(Bout)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge CLK);
    A = a;
    B = b;
    Bin = bin;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
  endtask
  task automatic wait_done(output int n, output logic stable);
    logic [W-1:0] prev;
    prev = D;
    stable = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
      if (Done) break;
      if (D !== prev) stable = 1'b0;
    end
  endtask
  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin);
    int n;
    logic st;
    logic [W:0] exp;
    exp = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    start_op(a, b, bin);
    chk({tag, "_busy"}, 16'(Busy), 16'd1);
    wait_done(n, st);
    chk({tag, "_latency"}, 16'(n), 16'd8);
    chk({tag, "_d"}, 16'(D), 16'(exp[W-1:0]));
    chk({tag, "_bout"}, 16'(Bout), 16'(exp[W]));
    chk({tag, "_stable"}, 16'(st), 16'd1);
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_done_width"}, 16'(Done), 16'd0);
    chk({tag, "_busy_end"}, 16'(Busy), 16'd0);
  endtask
  initial begin
    int n, dones;
    logic st;
    logic [W-1:0] ra, rb;
    logic rbin;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", 16'(Busy), 16'd0);
    chk("rst_done", 16'(Done), 16'd0);
    chk("rst_d", 16'(D), 16'd0);
    chk("rst_bout", 16'(Bout), 16'd0);
    op_check("v5a_3c", 8'h5A, 8'h3C, 1'b0);
    chk("v5a_3c_d_const", 16'(D), 16'h1E);
    op_check("v00_01", 8'h00, 8'h01, 1'b0);
    chk("v00_01_const", 16'({Bout, D}), 16'h1FF);
    op_check("v10_10_b", 8'h10, 8'h10, 1'b1);
    chk("v10_10_const", 16'({Bout, D}), 16'h1FF);
    op_check("vff_00", 8'hFF, 8'h00, 1'b0);
    chk("vff_00_const", 16'({Bout, D}), 16'h0FF);
    start_op(8'h80, 8'h01, 1'b0);
    A = 8'h00;
    B = 8'hFF;
    Start = 1'b1;
    repeat (3) @(negedge CLK);
    Start = 1'b0;
    wait_done(n, st);
    chk("ignore_latency", 16'(n), 16'd5);
    chk("ignore_d", 16'(D), 16'h7F);
    chk("ignore_bout", 16'(Bout), 16'd0);
    @(negedge CLK);
    chk("ignore_idle", 16'(Busy), 16'd0);
    A = 8'h20;
    B = 8'h05;
    Bin = 1'b1;
    Start = 1'b1;
    wait_done(n, st);
    chk("held_first", 16'(n), 16'd9);
    chk("held_d", 16'(D), 16'h1A);
    wait_done(n, st);
    chk("held_period", 16'(n), 16'd10);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("held_idle", 16'(Busy), 16'd0);
    start_op(8'hC3, 8'h11, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", 16'(Busy), 16'd0);
    chk("abort_done", 16'(Done), 16'd0);
    chk("abort_d", 16'(D), 16'd0);
    chk("abort_bout", 16'(Bout), 16'd0);
    dones = 0;
    repeat (12) begin
      @(negedge CLK);
      if (Done) dones++;
    end
    chk("abort_no_done", 16'(dones), 16'd0);
    op_check("v03_05", 8'h03, 8'h05, 1'b0);
    chk("v03_05_const", 16'({Bout, D}), 16'h1FE);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      op_check("rand", ra, rb, rbin);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
